// File: rtl/vga_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sel_pkg
//  Description : Shared types and default screen constants for the selection
//                rectangle, the VGA area checker and the VGA sync generator.
//  Contents    : sel_mode_t     - selection controller state encoding
//                c_h_res/c_v_res - visible screen size
//                c_step          - pixels per move/resize command
//                c_min_size      - smallest allowed width/height
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_sel_pkg;

    typedef enum logic [1:0] {
        SEL_MOVE   = 2'd0,
        SEL_RESIZE = 2'd1,
        SEL_LOCKED = 2'd2
    } sel_mode_t;

    localparam int c_h_res    = 640;
    localparam int c_v_res    = 480;
    localparam int c_step     = 4;
    localparam int c_min_size = 8;

endpackage
`default_nettype wire

// File: rtl/btn_edge_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : btn_edge_repeat
//  Description : Brings a raw asynchronous button level into the clk domain,
//                emits a one-cycle pulse on its rising edge (three cycles
//                after the pad edge) and, when EN_REPEAT is set, re-pulses
//                every REPEAT_CYC cycles while the button stays held.
//  Ports       : clk     in  1  system clock
//                rst_n   in  1  synchronous reset, active-low
//                i_btn   in  1  raw button level, active-high
//                o_pulse out 1  registered command pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_repeat #(
    parameter int REPEAT_CYC = 1 << 20,
    parameter bit EN_REPEAT  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;
    logic w_edge;
    logic w_rep;

    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        w_edge  = sync2_q & ~prev_q;
        pulse_d = w_edge | w_rep;
    end

    generate
        if (EN_REPEAT) begin : g_repeat
            localparam int CW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
            localparam logic [CW-1:0] c_last = CW'(REPEAT_CYC - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          w_held;
            logic          w_wrap;

            // Counting starts the cycle after the edge pulse, so the first
            // repeat lands exactly REPEAT_CYC cycles after it. Any release
            // clears the count, so a new press always starts a fresh period.
            always_comb begin
                w_held = sync2_q & prev_q;
                w_wrap = (cnt_q == c_last);
                cnt_d  = '0;
                if (w_held && !w_wrap) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            assign w_rep = w_held & w_wrap;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_no_repeat
            assign w_rep = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/user_selection_controller.sv
`default_nettype none
// ============================================================================
//  Module      : user_selection_controller
//  Description : Turns push-button commands into move/resize/lock operations
//                on the selection rectangle, clamped to the visible screen.
//                A shadow copy is edited; the active copy driving the outputs
//                is loaded only on frame_start so a frame never tears.
//  Ports       : clk           in  1  system clock
//                rst_n         in  1  synchronous reset, active-low
//                btn_up/down/left/right in 1  raw direction buttons
//                btn_mode      in  1  raw button, toggles MOVE/RESIZE
//                btn_confirm   in  1  raw button, locks/unlocks
//                frame_start   in  1  one-cycle pulse at vertical blank
//                x_pos, y_pos  out N  active top-left corner
//                width, height out N  active size
//                sel_valid     out 1  active copy is LOCKED
//                mode          out 2  active state (sel_mode_t)
//  Revision    : 1.0 - initial release
// ============================================================================
module user_selection_controller
    import vga_sel_pkg::*;
#(
    parameter int N          = 10,
    parameter int H_RES      = c_h_res,
    parameter int V_RES      = c_v_res,
    parameter int STEP       = c_step,
    parameter int MIN_SIZE   = c_min_size,
    parameter int INIT_X     = 0,
    parameter int INIT_Y     = 0,
    parameter int INIT_W     = 64,
    parameter int INIT_H     = 64,
    parameter int REPEAT_CYC = 1 << 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_mode,
    input  logic         btn_confirm,
    input  logic         frame_start,
    output logic [N-1:0] x_pos,
    output logic [N-1:0] y_pos,
    output logic [N-1:0] width,
    output logic [N-1:0] height,
    output logic         sel_valid,
    output logic [1:0]   mode
);

    localparam int W = N + 1;
    localparam logic [W-1:0] c_h    = W'(H_RES);
    localparam logic [W-1:0] c_v    = W'(V_RES);
    localparam logic [W-1:0] c_stp  = W'(STEP);
    localparam logic [W-1:0] c_min  = W'(MIN_SIZE);
    localparam logic [W-1:0] c_shr  = W'(STEP + MIN_SIZE);

    logic w_up, w_down, w_left, w_right, w_mode, w_confirm;

    btn_edge_repeat #(.REPEAT_CYC(REPEAT_CYC), .EN_REPEAT(1'b1)) u_up (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_up), .o_pulse(w_up));
    btn_edge_repeat #(.REPEAT_CYC(REPEAT_CYC), .EN_REPEAT(1'b1)) u_down (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_down), .o_pulse(w_down));
    btn_edge_repeat #(.REPEAT_CYC(REPEAT_CYC), .EN_REPEAT(1'b1)) u_left (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_left), .o_pulse(w_left));
    btn_edge_repeat #(.REPEAT_CYC(REPEAT_CYC), .EN_REPEAT(1'b1)) u_right (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_right), .o_pulse(w_right));
    btn_edge_repeat #(.REPEAT_CYC(REPEAT_CYC), .EN_REPEAT(1'b0)) u_mode (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_mode), .o_pulse(w_mode));
    btn_edge_repeat #(.REPEAT_CYC(REPEAT_CYC), .EN_REPEAT(1'b0)) u_confirm (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_confirm), .o_pulse(w_confirm));

    // Grow/advance by STEP, saturating at lim (the largest legal value).
    function automatic logic [N-1:0] inc_clamp(input logic [W-1:0] v,
                                               input logic [W-1:0] lim);
        logic [W-1:0] s;
        s = v + c_stp;
        return (s > lim) ? lim[N-1:0] : s[N-1:0];
    endfunction

    // Move toward the origin by STEP, stopping at zero.
    function automatic logic [N-1:0] dec_clamp(input logic [W-1:0] v);
        logic [W-1:0] s;
        s = (v >= c_stp) ? (v - c_stp) : '0;
        return s[N-1:0];
    endfunction

    // Shrink by STEP, never below MIN_SIZE.
    function automatic logic [N-1:0] shrink(input logic [W-1:0] v);
        logic [W-1:0] s;
        s = (v < c_shr) ? c_min : (v - c_stp);
        return s[N-1:0];
    endfunction

    sel_mode_t    state_q, state_d;
    logic [N-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    sel_mode_t    act_state_q;
    logic [N-1:0] act_x_q, act_y_q, act_w_q, act_h_q;
    logic         act_valid_q;
    logic [W-1:0] w_xe, w_ye, w_we, w_he;

    always_comb begin
        w_xe    = {1'b0, x_q};
        w_ye    = {1'b0, y_q};
        w_we    = {1'b0, w_q};
        w_he    = {1'b0, h_q};
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        // confirm > mode > direction; a direction pulse that shares its
        // cycle with mode or confirm is simply dropped.
        if (w_confirm) begin
            state_d = (state_q == SEL_LOCKED) ? SEL_MOVE : SEL_LOCKED;
        end else if (w_mode) begin
            if (state_q == SEL_MOVE) begin
                state_d = SEL_RESIZE;
            end else if (state_q == SEL_RESIZE) begin
                state_d = SEL_MOVE;
            end
        end else if (state_q == SEL_MOVE) begin
            if (w_up)         y_d = dec_clamp(w_ye);
            else if (w_down)  y_d = inc_clamp(w_ye, c_v - w_he);
            else if (w_left)  x_d = dec_clamp(w_xe);
            else if (w_right) x_d = inc_clamp(w_xe, c_h - w_we);
        end else if (state_q == SEL_RESIZE) begin
            if (w_up)         h_d = shrink(w_he);
            else if (w_down)  h_d = inc_clamp(w_he, c_v - w_ye);
            else if (w_left)  w_d = shrink(w_we);
            else if (w_right) w_d = inc_clamp(w_we, c_h - w_xe);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SEL_MOVE;
            x_q         <= N'(INIT_X);
            y_q         <= N'(INIT_Y);
            w_q         <= N'(INIT_W);
            h_q         <= N'(INIT_H);
            act_state_q <= SEL_MOVE;
            act_x_q     <= N'(INIT_X);
            act_y_q     <= N'(INIT_Y);
            act_w_q     <= N'(INIT_W);
            act_h_q     <= N'(INIT_H);
            act_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            // The active copy samples the shadow's current value, so an
            // update landing on the same edge waits for the next frame.
            if (frame_start) begin
                act_state_q <= state_q;
                act_x_q     <= x_q;
                act_y_q     <= y_q;
                act_w_q     <= w_q;
                act_h_q     <= h_q;
                act_valid_q <= (state_q == SEL_LOCKED);
            end
        end
    end

    assign x_pos     = act_x_q;
    assign y_pos     = act_y_q;
    assign width     = act_w_q;
    assign height    = act_h_q;
    assign sel_valid = act_valid_q;
    assign mode      = act_state_q;

endmodule
`default_nettype wire
